// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Transmit-side link between the UART control block and the serializer.
//   data_tx    byte to enqueue (controller -> serializer)
//   transmit   enqueue request, rising edge acts (controller -> serializer)
//   tx         serial line, idle high (serializer -> pin)
//   busy       queue non-empty or frame on the line
//   fifo_full  queue holds FIFO_DEPTH entries
//   fifo_count current queue occupancy
//   overflow   one-cycle pulse when a push is dropped
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    data_tx;
    logic          transmit;
    logic          tx;
    logic          busy;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output data_tx, transmit,
        input  tx, busy, fifo_full, fifo_count, overflow
    );

    modport slave (
        input  data_tx, transmit,
        output tx, busy, fifo_full, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART 8N1 serializer fed by a circular byte FIFO. Bytes are enqueued on
// rising edges of bus.transmit and shifted out LSB-first on bus.tx.
// Consecutive queued bytes go out back-to-back with no idle gap.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    uart_tx_fifo_if.slave: data_tx, transmit in;
//          tx, busy, fifo_full, fifo_count, overflow out
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_r, tx_n;
    logic          transmit_q;
    logic          overflow_r;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic push, pop, accept, full, baud_done;

    assign full      = (count == FULL_CNT);
    assign push      = bus.transmit & ~transmit_q;
    // A full FIFO still accepts when the FSM pops in the same cycle.
    assign accept    = push & (~full | pop);
    assign baud_done = (baud_cnt == BAUD_LAST);

    // Next-state, pop and next-line-level logic.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shreg_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (count != '0) begin
                        pop     = 1'b1;
                        shreg_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is registered from the next state so tx changes on the
        // same edge the state does.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx_r       <= 1'b1;
            transmit_q <= 1'b0;
            overflow_r <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_idx    <= bit_n;
            shreg      <= shreg_n;
            tx_r       <= tx_n;
            transmit_q <= bus.transmit;
            overflow_r <= push & ~accept;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; only pointer/count state matters.
    always_ff @(posedge clk) begin
        if (!reset && accept) mem[wr_ptr] <= bus.data_tx;
    end

    assign bus.tx         = tx_r;
    assign bus.busy       = (state != IDLE) | (count != '0);
    assign bus.fifo_full  = full;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: stimulus pushes the bytes it expects on the line.
    logic [7:0] exp_q[$];
    int         start_times[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decodes 8N1 frames, sampling mid-bit.
    logic       prev_tx   = 1'b1;
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = '0;
    int         frames    = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (prev_tx && !bus.tx) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                start_times.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                int k;
                k = rx_cnt / CPB;
                if (k == 0) begin
                    chk("start_bit", int'(bus.tx), 0);
                end else if (k <= 8) begin
                    rx_byte[k-1] = bus.tx;
                end else begin
                    chk("stop_bit", int'(bus.tx), 1);
                    frames++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_frame: got 0x%02h expected no frame", rx_byte);
                    end else begin
                        chk("rx_byte", int'(rx_byte), int'(exp_q.pop_front()));
                    end
                    rx_active = 1'b0;
                end
            end
        end
        prev_tx = bus.tx;
    end

    // Status observers.
    int   ovf_cycles = 0;
    logic full_seen  = 1'b0;
    int   peak       = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.overflow) ovf_cycles++;
            if (bus.fifo_full) full_seen = 1'b1;
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        bus.data_tx  = b;
        bus.transmit = 1'b1;
        @(negedge clk);
        bus.transmit = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy && !rx_active) break;
        end
        chk(name, int'(bus.busy), 0);
    endtask

    initial begin
        int f0;
        int bc;
        reset        = 1'b1;
        bus.transmit = 1'b0;
        bus.data_tx  = 8'h00;

        // Reset held 20 cycles.
        repeat (20) @(negedge clk);
        chk("rst_tx", int'(bus.tx), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_count", int'(bus.fifo_count), 0);
        chk("rst_full", int'(bus.fifo_full), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte: latency and busy width.
        exp_q.push_back(8'hA5);
        @(negedge clk);
        bus.data_tx  = 8'hA5;
        bus.transmit = 1'b1;
        @(negedge clk);
        bus.transmit = 1'b0;
        chk("a5_tx_after_push", int'(bus.tx), 1);
        chk("a5_busy_rise", int'(bus.busy), 1);
        chk("a5_count", int'(bus.fifo_count), 1);
        bc = 1;
        @(negedge clk);
        chk("a5_start_fall", int'(bus.tx), 0);
        chk("a5_count_popped", int'(bus.fifo_count), 0);
        if (bus.busy) bc++;
        for (int i = 0; i < 400 && bus.busy; i++) begin
            @(negedge clk);
            if (bus.busy) bc++;
        end
        chk("a5_busy_cycles", bc, 161);
        wait_idle("a5_idle", 50);

        // Held transmit: exactly one frame; data_tx changes mid-frame are ignored.
        f0 = frames;
        peak = 0;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        bus.data_tx  = 8'h3C;
        bus.transmit = 1'b1;
        repeat (50) @(negedge clk);
        bus.data_tx = 8'hFF;
        repeat (450) @(negedge clk);
        bus.transmit = 1'b0;
        wait_idle("hold_idle", 400);
        chk("hold_frames", frames - f0, 1);
        chk("hold_peak", peak, 1);

        // Five quick pushes: back-to-back frames, FIFO fills, no overflow.
        start_times.delete();
        full_seen = 1'b0;
        f0 = frames;
        for (int b = 1; b <= 5; b++) begin
            exp_q.push_back(8'(b));
            push(8'(b));
        end
        wait_idle("burst_idle", 1200);
        chk("burst_frames", frames - f0, 5);
        chk("burst_starts", start_times.size(), 5);
        for (int i = 1; i < 5 && i < start_times.size(); i++)
            chk("burst_gap", start_times[i] - start_times[i-1], 10 * CPB);
        chk("burst_full_seen", int'(full_seen), 1);
        chk("no_overflow_so_far", ovf_cycles, 0);

        // Six quick pushes: the sixth finds the FIFO full and is dropped.
        ovf_cycles = 0;
        f0 = frames;
        for (int b = 0; b < 6; b++) begin
            if (b < 5) exp_q.push_back(8'(8'h11 + b));
            push(8'(8'h11 + b));
        end
        wait_idle("ovf_idle", 1200);
        chk("ovf_pulse_cycles", ovf_cycles, 1);
        chk("ovf_frames", frames - f0, 5);

        // Reset in the middle of the data bits of 0xFF.
        exp_q.push_back(8'hFF);
        push(8'hFF);
        repeat (70) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_tx", int'(bus.tx), 1);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_count", int'(bus.fifo_count), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        f0 = frames;
        exp_q.push_back(8'h55);
        push(8'h55);
        wait_idle("post_rst_idle", 400);
        chk("post_rst_frames", frames - f0, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
